// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 LCD driver (8-bit, write-only): power-up init, then line 1 shows `a` and line 2 shows `b` as hex.
// Optional LCD_SKIP_UNCHANGED_EN: after each frame, idle in HOLD until {a,b} differs from the last snapshot.
module lcd_hex_driver #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned POWERUP_CYC = CLK_HZ / 25,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned E_PULSE_CYC = 15,
    parameter int unsigned CMD_CYC     = CLK_HZ / 20_000,
    parameter int unsigned CLEAR_CYC   = CLK_HZ / 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        LCD_RS,
    output logic        LCD_E,
    output logic [7:0]  LCD_D,
    output logic        frame_done
);

    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    localparam int unsigned MAX_CYC     = max2(max2(POWERUP_CYC, SETUP_CYC),
                                               max2(max2(E_PULSE_CYC, CMD_CYC), CLEAR_CYC));
    localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);
    localparam int unsigned SLOT_W      = 6;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned FRAME_FIRST = 6;
    localparam int unsigned FRAME_LAST  = 39;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_PULSE,
`ifdef LCD_SKIP_UNCHANGED_EN
        ST_WAIT,
        ST_HOLD
`else
        ST_WAIT
`endif
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SLOT_W-1:0]   slot, slot_nxt;
    logic                rs_q, rs_nxt;
    logic                e_q, e_nxt;
    logic [BYTE_W-1:0]   d_q, d_nxt;
    logic                done_q, done_nxt;
    logic [63:0]         a_snap, a_snap_nxt;
    logic [63:0]         b_snap, b_snap_nxt;

    logic                load;
    logic [SLOT_W-1:0]   load_slot;
    logic                is_clear;
    logic [CNT_W-1:0]    wait_last;

    // Nibble i of w, counting from the most significant nibble.
    function automatic logic [3:0] nib(input logic [63:0] w, input logic [3:0] i);
        return w[{~i, 2'b00} +: 4];
    endfunction

    function automatic logic [BYTE_W-1:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // {RS, D} for a slot: 0..5 are init commands, 6..39 are the frame.
    function automatic logic [BYTE_W:0] slot_byte(input logic [SLOT_W-1:0] s,
                                                  input logic [63:0] sa,
                                                  input logic [63:0] sb);
        logic [SLOT_W-1:0] f;
        logic [BYTE_W:0]   r;
        f = s - SLOT_W'(FRAME_FIRST);
        case (s)
            6'd0, 6'd1, 6'd2: r = {1'b0, 8'h38};
            6'd3:             r = {1'b0, 8'h0C};
            6'd4:             r = {1'b0, 8'h01};
            6'd5:             r = {1'b0, 8'h06};
            default: begin
                if (f == 6'd0)
                    r = {1'b0, 8'h80};
                else if (f <= 6'd16)
                    r = {1'b1, hex_char(nib(sa, 4'(f - 6'd1)))};
                else if (f == 6'd17)
                    r = {1'b0, 8'hC0};
                else
                    r = {1'b1, hex_char(nib(sb, 4'(f - 6'd18)))};
            end
        endcase
        return r;
    endfunction

    assign is_clear  = !rs_q && (d_q == 8'h01);
    assign wait_last = is_clear ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(CMD_CYC - 1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_PWRUP;
            cnt    <= '0;
            slot   <= '0;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            d_q    <= '0;
            done_q <= 1'b0;
            a_snap <= '0;
            b_snap <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            slot   <= slot_nxt;
            rs_q   <= rs_nxt;
            e_q    <= e_nxt;
            d_q    <= d_nxt;
            done_q <= done_nxt;
            a_snap <= a_snap_nxt;
            b_snap <= b_snap_nxt;
        end
    end

    // Next-state logic; `load` starts the SETUP phase of load_slot.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CNT_W'(1);
        slot_nxt   = slot;
        rs_nxt     = rs_q;
        e_nxt      = 1'b0;
        d_nxt      = d_q;
        done_nxt   = 1'b0;
        a_snap_nxt = a_snap;
        b_snap_nxt = b_snap;
        load       = 1'b0;
        load_slot  = slot;

        case (state)
            ST_PWRUP: begin
                if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
                    load      = 1'b1;
                    load_slot = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = '0;
                end
                e_nxt = (cnt == CNT_W'(SETUP_CYC - 1));
            end
            ST_PULSE: begin
                e_nxt = 1'b1;
                if (cnt == CNT_W'(E_PULSE_CYC - 1)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                    e_nxt     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt == wait_last) begin
                    if (slot == SLOT_W'(FRAME_LAST)) begin
                        done_nxt = 1'b1;
`ifdef LCD_SKIP_UNCHANGED_EN
                        state_nxt = ST_HOLD;
                        cnt_nxt   = '0;
`else
                        load      = 1'b1;
                        load_slot = SLOT_W'(FRAME_FIRST);
`endif
                    end else begin
                        load      = 1'b1;
                        load_slot = slot + SLOT_W'(1);
                    end
                end
            end
`ifdef LCD_SKIP_UNCHANGED_EN
            ST_HOLD: begin
                cnt_nxt = '0;
                if ({a, b} != {a_snap, b_snap}) begin
                    load      = 1'b1;
                    load_slot = SLOT_W'(FRAME_FIRST);
                end
            end
`endif
            default: begin
                state_nxt = ST_PWRUP;
                cnt_nxt   = '0;
            end
        endcase

        if (load) begin
            state_nxt         = ST_SETUP;
            cnt_nxt           = '0;
            slot_nxt          = load_slot;
            {rs_nxt, d_nxt}   = slot_byte(load_slot, a_snap, b_snap);
            if (load_slot == SLOT_W'(FRAME_FIRST)) begin
                a_snap_nxt = a;
                b_snap_nxt = b;
            end
        end
    end

    assign LCD_RS     = rs_q;
    assign LCD_E      = e_q;
    assign LCD_D      = d_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Directed bench for lcd_hex_driver: init sequence, frame decode, snapshot timing, reset, optional HOLD.
module tb_lcd_hex_driver;

    localparam logic [63:0] A0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B0 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] A1 = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] B1 = 64'hFEDC_BA98_7654_3211;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a, b;
    logic        LCD_RS, LCD_E;
    logic [7:0]  LCD_D;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int stamps[$];

    lcd_hex_driver #(
        .POWERUP_CYC(50), .SETUP_CYC(2), .E_PULSE_CYC(3), .CMD_CYC(10), .CLEAR_CYC(20)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .LCD_RS(LCD_RS), .LCD_E(LCD_E), .LCD_D(LCD_D), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done) stamps.push_back(cyc);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until E rises (gap = edges taken), capture RS/D, then count E-high cycles.
    task automatic next_strobe(output logic [7:0] d, output logic rs, output int gap, output int width);
        gap = 0;
        do begin step(); gap++; end while (!LCD_E && gap < 5000);
        if (!LCD_E) check_eq("strobe_timeout", 32'(gap), 32'd0);
        d = LCD_D;
        rs = LCD_RS;
        width = 0;
        do begin
            step();
            width++;
            if (LCD_E && LCD_D !== d) check_eq("d_hold", 32'(LCD_D), 32'(d));
        end while (LCD_E && width < 100);
    endtask

    // Decode one 34-slot frame; optionally change `a` after strobe chg_at.
    task automatic decode_frame(input string l1, input string l2, input int chg_at,
                                input logic [63:0] new_a, output int first_gap);
        logic [7:0] d, ed;
        logic       rs, ers;
        int         g, w;
        for (int i = 0; i < 34; i++) begin
            next_strobe(d, rs, g, w);
            if (i == 0) first_gap = g;
            if (i == 0)       begin ers = 1'b0; ed = 8'h80; end
            else if (i <= 16) begin ers = 1'b1; ed = l1[i-1]; end
            else if (i == 17) begin ers = 1'b0; ed = 8'hC0; end
            else              begin ers = 1'b1; ed = l2[i-18]; end
            check_eq($sformatf("frame_slot%0d", i), {23'd0, rs, d}, {23'd0, ers, ed});
            if (i == chg_at) a = new_a;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       rs;
        int         g, w, eh;
        logic [7:0] init_b[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        int         init_g[6] = '{52, 12, 12, 12, 12, 22};

        reset = 1'b1;
        a = A0;
        b = B0;
        repeat (3) step();
        check_eq("rst_e", 32'(LCD_E), 32'd0);
        check_eq("rst_rs_d", {23'd0, LCD_RS, LCD_D}, 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            next_strobe(d, rs, g, w);
            check_eq($sformatf("init_byte%0d", i), {23'd0, rs, d}, {24'd0, init_b[i]});
            check_eq($sformatf("init_gap%0d", i), 32'(g), 32'(init_g[i]));
            check_eq($sformatf("init_width%0d", i), 32'(w), 32'd3);
        end

        decode_frame("0123456789ABCDEF", "FEDCBA9876543210", -1, A0, g);
        check_eq("frame1_gap", 32'(g), 32'd12);

`ifdef LCD_SKIP_UNCHANGED_EN
        g = 0;
        while (!frame_done && g < 100) begin step(); g++; end
        check_eq("hold_done_seen", 32'(frame_done), 32'd1);
        eh = 0;
        repeat (2000) begin step(); if (LCD_E) eh++; end
        check_eq("hold_no_e", 32'(eh), 32'd0);
        b = B1;
        decode_frame("0123456789ABCDEF", "FEDCBA9876543211", 8, A1, g);
        check_eq("hold_restart_gap", 32'(g), 32'd3);
        decode_frame("5555AAAA5555AAAA", "FEDCBA9876543211", -1, A1, g);
        b = B0;
`else
        decode_frame("0123456789ABCDEF", "FEDCBA9876543210", 8, A1, g);
        check_eq("frame2_gap", 32'(g), 32'd12);
        decode_frame("5555AAAA5555AAAA", "FEDCBA9876543210", -1, A1, g);
        check_eq("frame3_gap", 32'(g), 32'd12);
        check_eq("done_count", 32'(stamps.size()), 32'd2);
        if (stamps.size() >= 2)
            check_eq("done_period", 32'(stamps[1] - stamps[0]), 32'd510);
`endif

        // Reset while E is high.
        g = 0;
        while (!LCD_E && g < 5000) begin step(); g++; end
        check_eq("pre_reset_e", 32'(LCD_E), 32'd1);
        reset = 1'b1;
        step();
        check_eq("midrst_e", 32'(LCD_E), 32'd0);
        check_eq("midrst_rs_d", {23'd0, LCD_RS, LCD_D}, 32'd0);
        check_eq("midrst_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        next_strobe(d, rs, g, w);
        check_eq("post_rst_gap", 32'(g), 32'd52);
        check_eq("post_rst_byte", {23'd0, rs, d}, 32'h038);
        check_eq("post_rst_width", 32'(w), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
